// File: rtl/rw_sched_pkg.sv
// rtl/rw_sched_pkg.sv - shared states, defaults and helpers for the step scheduler
package rw_sched_pkg;

  localparam int DEFAULT_NREQ = 2;
  localparam int DEFAULT_W    = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    RESP   = 2'd2,
    HALTED = 2'd3
  } schedState_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rw_rr_arbiter.sv
// rtl/rw_rr_arbiter.sv - one-hot round-robin grant starting at a given pointer
module rw_rr_arbiter
  import rw_sched_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int PW   = idWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [NREQ-1:0] rotReq;
  logic [NREQ-1:0] rotGrant;

  // Rotate so the pointer index sits at bit 0, isolate the lowest set bit,
  // then rotate back. Duplicating the vector turns the rotation into a shift.
  assign rotReq   = NREQ'({req, req} >> ptr);
  assign rotGrant = rotReq & (~rotReq + ONE);
  assign grant    = NREQ'(({rotGrant, rotGrant} << ptr) >> NREQ);

endmodule

// File: rtl/rw_step_scheduler.sv
// rtl/rw_step_scheduler.sv - round-robin scheduler sharing one resumption core; optional RW_STEP_SCHED_STATS_EN counters
module rw_step_scheduler
  import rw_sched_pkg::*;
#(
  parameter  int NREQ = DEFAULT_NREQ,
  parameter  int W    = DEFAULT_W,
  localparam int IDW  = idWidth(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_last,
  output logic [W-1:0]      core_in,
  output logic              core_step,
  input  logic [W-1:0]      core_out,
  input  logic              core_continue,
  output logic              core_restart,
  input  logic              restart,
  output logic              halted
`ifdef RW_STEP_SCHED_STATS_EN
  ,
  output logic [15:0]       step_count,
  output logic [15:0]       halt_count
`endif
);

  schedState_t     state;
  logic [IDW-1:0]  rrPtr;
  logic [IDW-1:0]  curId;
  logic [IDW-1:0]  grantIdx;
  logic [IDW-1:0]  nextPtr;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    grantData;
  logic            accept;

  rw_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (IDW)
  ) uArb (
    .req   (req_valid),
    .ptr   (rrPtr),
    .grant (grant)
  );

  // The arbiter's choice is only offered while idle.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // Search restarts one past the requester just served.
  assign nextPtr = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + IDW'(1);

  // Decode the one-hot grant into an index and pick that requester's word.
  always_comb begin
    grantIdx  = '0;
    grantData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grantIdx  = IDW'(i);
        grantData = req_data[i*W +: W];
      end
    end
  end

  // Main sequencer: accept, step the core once, hold the result, maybe halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rrPtr        <= '0;
      curId        <= '0;
      core_in      <= '0;
      core_step    <= 1'b0;
      core_restart <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      rsp_last     <= 1'b0;
      halted       <= 1'b0;
    end else begin
      core_step    <= 1'b0;
      core_restart <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            core_in   <= grantData;
            curId     <= grantIdx;
            rrPtr     <= nextPtr;
            core_step <= 1'b1;
            state     <= STEP;
          end
        end
        STEP: begin
          rsp_data  <= core_out;
          rsp_id    <= curId;
          rsp_last  <= !core_continue;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALTED: begin
          if (restart) begin
            halted       <= 1'b0;
            core_restart <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RW_STEP_SCHED_STATS_EN
  logic enterHalt;
  assign enterHalt = (state == RESP) && rsp_ready && rsp_last;

  // Activity counters: steps wrap, halt entries saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_count <= '0;
      halt_count <= '0;
    end else begin
      if (core_step) step_count <= step_count + 16'd1;
      if (enterHalt && (halt_count != 16'hFFFF)) halt_count <= halt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rw_step_scheduler.sv
// tb/tb_rw_step_scheduler.sv - self-checking bench for rw_step_scheduler
module tb_rw_step_scheduler;

  localparam int NREQ = 3;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_last;
  logic [W-1:0]      core_in;
  logic              core_step;
  logic [W-1:0]      core_out;
  logic              core_continue = 1'b1;
  logic              core_restart;
  logic              restart = 1'b0;
  logic              halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Core model: output word is the input word plus one.
  assign core_out = core_in + 4'd1;

  rw_step_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .rsp_last      (rsp_last),
    .core_in       (core_in),
    .core_step     (core_step),
    .core_out      (core_out),
    .core_continue (core_continue),
    .core_restart  (core_restart),
    .restart       (restart),
    .halted        (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           last;
  } rsp_t;

  rsp_t sbq[$];

  // Scoreboard: sample just before each rising edge, push on accept, pop on response.
  always @(negedge clk) begin
    rsp_t e;
    #4;
    if (!rst) begin
      sbq.delete();
    end else begin
      check("ready_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = IDW'(i);
          e.data = req_data[i*W +: W] + 4'd1;
          e.last = !core_continue;
          sbq.push_back(e);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("sb_rsp", {25'd0, rsp_id, rsp_data, rsp_last}, {25'd0, e.id, e.data, e.last});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  valid;
    logic [11:0] data;
    logic [2:0]  expGrant;
    logic [1:0]  expId;
    logic [3:0]  expIn;
    logic [3:0]  expRsp;
  } vec_t;

  vec_t tbl[8];
  int   grants;
  int   lastCyc;
  logic [2:0] expOh;
  logic found;

  initial begin
    tbl[0] = '{3'b001, 12'h001, 3'b001, 2'd0, 4'h1, 4'h2};
    tbl[1] = '{3'b111, 12'h345, 3'b010, 2'd1, 4'h4, 4'h5};
    tbl[2] = '{3'b111, 12'h9AB, 3'b100, 2'd2, 4'h9, 4'hA};
    tbl[3] = '{3'b110, 12'h7C0, 3'b010, 2'd1, 4'hC, 4'hD};
    tbl[4] = '{3'b001, 12'h00F, 3'b001, 2'd0, 4'hF, 4'h0};
    tbl[5] = '{3'b101, 12'h605, 3'b100, 2'd2, 4'h6, 4'h7};
    tbl[6] = '{3'b010, 12'h0E0, 3'b010, 2'd1, 4'hE, 4'hF};
    tbl[7] = '{3'b100, 12'h800, 3'b100, 2'd2, 4'h8, 4'h9};

    // Reset values
    @(negedge clk); #1;
    check("rst_core_restart", core_restart, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_core_step", core_step, 0);
    check("rst_halted", halted, 0);
    check("rst_rsp_fields", {rsp_id, rsp_data, rsp_last}, 0);
    check("rst_core_in", core_in, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_core_restart", core_restart, 0);

    // Table: grant order, step timing, captured result
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid; req_data = tbl[v].data; rsp_ready = 1'b1; core_continue = 1'b1;
      #1 check($sformatf("v%0d_grant", v), req_ready, tbl[v].expGrant);
      @(negedge clk); req_valid = '0;
      #1 check($sformatf("v%0d_core_step", v), core_step, 1);
      check($sformatf("v%0d_core_in", v), core_in, tbl[v].expIn);
      @(negedge clk); #1;
      check($sformatf("v%0d_rsp_valid", v), rsp_valid, 1);
      check($sformatf("v%0d_rsp", v), {rsp_id, rsp_data, rsp_last}, {tbl[v].expId, tbl[v].expRsp, 1'b0});
      check($sformatf("v%0d_step_once", v), core_step, 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_rsp_done", v), rsp_valid, 0);
    end

    // Contention between requesters 0 and 1: alternate, one grant per 3 cycles
    @(negedge clk);
    req_valid = 3'b011; req_data = 12'h021; rsp_ready = 1'b1;
    grants = 0; lastCyc = 0; expOh = 3'b001;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready != 3'b000) begin
        check("rr_alternate", req_ready, expOh);
        if (grants > 0) check("rr_spacing", c - lastCyc, 3);
        lastCyc = c;
        expOh = (expOh == 3'b001) ? 3'b010 : 3'b001;
        grants++;
      end
    end
    check("rr_grant_count", grants, 4);
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);

    // Backpressure: result held, no grant, no extra step
    req_valid = 3'b001; req_data = 12'h003; rsp_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (rsp_valid) found = 1'b1;
    end
    check("bp_rsp_seen", found, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_last}, {1'b1, 2'd0, 4'h4, 1'b0});
      check("bp_no_ready", req_ready, 0);
      check("bp_no_step", core_step, 0);
    end
    @(negedge clk); rsp_ready = 1'b1; req_valid = '0;
    @(negedge clk); #1 check("bp_released", rsp_valid, 0);

    // Restart outside HALTED is ignored
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    #1 check("restart_ignored", {core_restart, halted}, 0);

    // Halt: last step, requests ignored, restart pulse
    @(negedge clk);
    req_valid = 3'b010; req_data = 12'h050; core_continue = 1'b0; rsp_ready = 1'b1;
    #1 check("halt_grant", req_ready, 3'b010);
    @(negedge clk); req_valid = '0;
    #1 check("halt_step", core_step, 1);
    @(negedge clk); #1;
    check("halt_rsp", {rsp_valid, rsp_id, rsp_data, rsp_last}, {1'b1, 2'd1, 4'h6, 1'b1});
    @(negedge clk); #1;
    check("halted_set", {halted, rsp_valid}, 2'b10);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); req_valid = 3'b111;
      #1 check("halted_no_ready", req_ready, 0);
      check("halted_no_step", {core_step, halted}, 2'b01);
    end
    @(negedge clk); restart = 1'b1; core_continue = 1'b1;
    #1 check("restart_not_yet", core_restart, 0);
    @(negedge clk); restart = 1'b0;
    #1 check("restart_pulse", {core_restart, halted}, 2'b10);
    check("restart_idle_grant", req_ready, 3'b100);
    @(negedge clk); req_valid = '0;
    #1 check("restart_one_cycle", {core_restart, core_step}, 2'b01);
    repeat (3) @(negedge clk);

    // Reset during RESP discards the result; next grant goes to requester 0
    req_valid = 3'b010; req_data = 12'h0D0; rsp_ready = 1'b0;
    #1 check("mid_rst_grant", req_ready, 3'b010);
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1 check("mid_rst_in_resp", rsp_valid, 1);
    @(negedge clk); rst = 1'b0;
    #1 check("mid_rst_drop", {rsp_valid, core_step, halted}, 0);
    check("mid_rst_core_restart", core_restart, 1);
    @(negedge clk); rst = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); req_valid = 3'b111; req_data = 12'h123;
    #1 check("after_rst_grant", req_ready, 3'b001);
    check("after_rst_restart_low", core_restart, 0);
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);

    check("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
